// File: rtl/conv_pkg.sv
// Shared types and helpers for the point-wise convolution stream engine:
// FSM state encoding, width derivations and signed saturation.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int out_width(input int bw, input int dbl);
    return bw * (dbl + 1);
  endfunction

  // Full-precision accumulator: product width plus growth for IN_CHANNEL
  // terms plus one guard bit, so the running sum can never overflow.
  function automatic int acc_width(input int bw, input int in_ch);
    return 2 * bw + clog2(in_ch) + 1;
  endfunction

  // Clamp a signed value into the signed range of the given width.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                   input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/pw_mac_lane.sv
// One output channel of the point-wise convolution: signed MAC accumulator,
// saturation to the output width and optional ReLU / clamp activation.
module pw_mac_lane
  import conv_pkg::*;
#(
  parameter int BITWIDTH           = 8,
  parameter int OUT_W              = 16,
  parameter int ACC_W              = 19,
  parameter int USING_ACTIVATION   = 1,
  parameter int ACTIVATION_IS_RELU = 1,
  parameter int ACTIVATION_MAX_VAL = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic [ACC_W-1:0]    init_val,
  input  logic                mac_en,
  input  logic [BITWIDTH-1:0] px,
  input  logic [BITWIDTH-1:0] weight,
  input  logic                act_en,
  output logic [OUT_W-1:0]    result
);

  localparam logic signed [OUT_W-1:0] MAX_VAL = OUT_W'(ACTIVATION_MAX_VAL);

  logic signed [ACC_W-1:0]      acc;
  logic signed [2*BITWIDTH-1:0] prod;
  logic signed [OUT_W-1:0]      sat_val;
  logic signed [OUT_W-1:0]      act_val;

  assign prod    = $signed(px) * $signed(weight);
  assign sat_val = OUT_W'(sat_signed(64'(acc), OUT_W));

  // Accumulator: seeded on pixel accept, one product added per MAC cycle.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      acc <= '0;
    end else if (init) begin
      acc <= $signed(init_val);
    end else if (mac_en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  // Activation on the saturated sum.
  always_comb begin
    // NOTE: default assignment first so no path leaves act_val unassigned,
    // which would otherwise infer a latch.
    act_val = sat_val;
    if (USING_ACTIVATION != 0) begin
      if (sat_val[OUT_W-1]) begin
        act_val = '0;
      end else if (ACTIVATION_IS_RELU == 0 && sat_val > MAX_VAL) begin
        act_val = MAX_VAL;
      end
    end
  end

  // Output register, loaded once per pixel in the ACT state.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (act_en) begin
      result <= act_val;
    end
  end

endmodule

// File: rtl/conv2d_pw_stream.sv
// Streaming 1x1 (point-wise) convolution: OUT_CHANNEL MAC lanes in parallel,
// iterating serially over IN_CHANNEL inputs. Weights live in an internal
// register file written through w_wr_*.
// Optional bias: define CONV2D_PW_BIAS_EN to map bias[oc] at address
// IN_CHANNEL*OUT_CHANNEL+oc and seed each accumulator with it.
module conv2d_pw_stream
  import conv_pkg::*;
#(
  parameter int BITWIDTH                 = 8,
  parameter int IS_BITWIDTH_DOUBLE_SCALE = 1,
  parameter int IN_CHANNEL               = 4,
  parameter int OUT_CHANNEL              = 8,
  parameter int USING_ACTIVATION         = 1,
  parameter int ACTIVATION_IS_RELU       = 1,
  parameter int ACTIVATION_MAX_VAL       = 6,
  localparam int OUT_W = out_width(BITWIDTH, IS_BITWIDTH_DOUBLE_SCALE),
  localparam int AW    = clog2(IN_CHANNEL * OUT_CHANNEL + OUT_CHANNEL)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           w_wr_en,
  input  logic [AW-1:0]                  w_wr_addr,
  input  logic [BITWIDTH-1:0]            w_wr_data,
  output logic                           w_wr_drop,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_CHANNEL*BITWIDTH-1:0] in_pixel,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_CHANNEL*OUT_W-1:0]   out_pixel,
  output logic                           busy
);

  localparam int ACC_W = acc_width(BITWIDTH, IN_CHANNEL);
  localparam int NW    = IN_CHANNEL * OUT_CHANNEL;
  localparam int ICW   = (IN_CHANNEL > 1) ? clog2(IN_CHANNEL) : 1;
`ifdef CONV2D_PW_BIAS_EN
  localparam int N_MAPPED = NW + OUT_CHANNEL;
`else
  localparam int N_MAPPED = NW;
`endif

  state_t              state;
  logic [ICW-1:0]      ic;
  logic [BITWIDTH-1:0] px_reg [IN_CHANNEL];
  logic [BITWIDTH-1:0] weight [OUT_CHANNEL][IN_CHANNEL];
  logic                accept;
  logic                wr_ok;
  logic                last_ic;

  assign in_ready = (state == IDLE) || (state == OUT && out_ready);
  assign accept   = in_valid && in_ready;
  assign wr_ok    = w_wr_en && (state == IDLE) && (int'(w_wr_addr) < N_MAPPED);
  assign last_ic  = (ic == ICW'(IN_CHANNEL - 1));
  assign busy     = (state != IDLE);

  // Weight register file; writes commit at the edge, ahead of the first MAC.
  always_ff @(posedge clk) begin
    // NOTE: coefficients must read back as zero after reset, so this storage
    // is reset explicitly (it is a flop array, not an inferred RAM).
    if (rst) begin
      for (int oc = 0; oc < OUT_CHANNEL; oc++)
        for (int i = 0; i < IN_CHANNEL; i++) weight[oc][i] <= '0;
    end else if (wr_ok) begin
      for (int oc = 0; oc < OUT_CHANNEL; oc++)
        for (int i = 0; i < IN_CHANNEL; i++)
          if (w_wr_addr == AW'(oc * IN_CHANNEL + i)) weight[oc][i] <= w_wr_data;
    end
  end

`ifdef CONV2D_PW_BIAS_EN
  logic [BITWIDTH-1:0] bias [OUT_CHANNEL];

  // Bias registers, mapped directly above the weight block.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int oc = 0; oc < OUT_CHANNEL; oc++) bias[oc] <= '0;
    end else if (wr_ok) begin
      for (int oc = 0; oc < OUT_CHANNEL; oc++)
        if (w_wr_addr == AW'(NW + oc)) bias[oc] <= w_wr_data;
    end
  end
`endif

  // Dropped-write pulse: busy engine or unmapped address.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_wr_drop <= 1'b0;
    end else begin
      w_wr_drop <= w_wr_en && !wr_ok;
    end
  end

  // Control FSM: input capture, channel counter and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ic        <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < IN_CHANNEL; i++) px_reg[i] <= '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < IN_CHANNEL; i++) px_reg[i] <= in_pixel[i*BITWIDTH +: BITWIDTH];
      end
      case (state)
        IDLE: begin
          if (accept) begin
            ic    <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (last_ic) begin
            ic    <= '0;
            state <= ACT;
          end else begin
            ic <= ic + ICW'(1);
          end
        end
        ACT: begin
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              ic    <= '0;
              state <= MAC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar oc = 0; oc < OUT_CHANNEL; oc++) begin : g_lane
    logic [ACC_W-1:0] init_val;
`ifdef CONV2D_PW_BIAS_EN
    assign init_val = ACC_W'($signed(bias[oc]));
`else
    assign init_val = '0;
`endif

    pw_mac_lane #(
      .BITWIDTH          (BITWIDTH),
      .OUT_W             (OUT_W),
      .ACC_W             (ACC_W),
      .USING_ACTIVATION  (USING_ACTIVATION),
      .ACTIVATION_IS_RELU(ACTIVATION_IS_RELU),
      .ACTIVATION_MAX_VAL(ACTIVATION_MAX_VAL)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .init    (accept),
      .init_val(init_val),
      .mac_en  (state == MAC),
      .px      (px_reg[ic]),
      .weight  (weight[oc][ic]),
      .act_en  (state == ACT),
      .result  (out_pixel[oc*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_conv2d_pw_stream.sv
// Directed bench for conv2d_pw_stream. Three instances share one stimulus
// stream: default ReLU (16-bit out), clamp-to-6, and 8-bit out without
// activation (saturation visible).
module tb_conv2d_pw_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        w_wr_en = 1'b0;
  logic [3:0]  w_wr_addr = '0;
  logic [7:0]  w_wr_data = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pixel = '0;
  logic        out_ready = 1'b1;

  logic        drop_a, in_ready, out_valid, busy;
  logic [31:0] out_pixel;
  logic        drop_c, in_ready_c, out_valid_c, busy_c;
  logic [31:0] out_pixel_c;
  logic        drop_s, in_ready_s, out_valid_s, busy_s;
  logic [15:0] out_pixel_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv2d_pw_stream #(.IN_CHANNEL(4), .OUT_CHANNEL(2)) u_dut (
    .clk(clk), .rst(rst), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
    .w_wr_data(w_wr_data), .w_wr_drop(drop_a), .in_valid(in_valid),
    .in_ready(in_ready), .in_pixel(in_pixel), .out_valid(out_valid),
    .out_ready(out_ready), .out_pixel(out_pixel), .busy(busy)
  );

  conv2d_pw_stream #(.IN_CHANNEL(4), .OUT_CHANNEL(2), .ACTIVATION_IS_RELU(0),
                     .ACTIVATION_MAX_VAL(6)) u_clamp (
    .clk(clk), .rst(rst), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
    .w_wr_data(w_wr_data), .w_wr_drop(drop_c), .in_valid(in_valid),
    .in_ready(in_ready_c), .in_pixel(in_pixel), .out_valid(out_valid_c),
    .out_ready(out_ready), .out_pixel(out_pixel_c), .busy(busy_c)
  );

  conv2d_pw_stream #(.IN_CHANNEL(4), .OUT_CHANNEL(2), .IS_BITWIDTH_DOUBLE_SCALE(0),
                     .USING_ACTIVATION(0)) u_sat (
    .clk(clk), .rst(rst), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
    .w_wr_data(w_wr_data), .w_wr_drop(drop_s), .in_valid(in_valid),
    .in_ready(in_ready_s), .in_pixel(in_pixel), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_pixel(out_pixel_s), .busy(busy_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pix(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  task automatic wr(input int addr, input logic [7:0] data);
    w_wr_en   = 1'b1;
    w_wr_addr = 4'(addr);
    w_wr_data = data;
    tick();
    w_wr_en   = 1'b0;
  endtask

  // Present a pixel until accepted; returns in the first cycle after accept.
  task automatic send(input logic [31:0] p);
    int n;
    in_valid = 1'b1;
    in_pixel = p;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  // Count cycles (accept cycle = 0) until out_valid; note any in_ready before it.
  task automatic wait_out(output int n, output logic saw_ready);
    n = 1;
    saw_ready = in_ready;
    while (!out_valid && n < 20) begin
      tick();
      n++;
      if (!out_valid) saw_ready = saw_ready | in_ready;
    end
    check("out_valid_seen", out_valid, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int   n;
    logic sr;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pixel", out_pixel, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_a, 1'b0);
    check("rst_aux", {drop_c, drop_s, busy_c, busy_s, in_ready_c, in_ready_s,
                      out_valid_c, out_valid_s}, 8'b0000_1100);

    // All weights 1, pixel {1,2,3,4} -> 10 per lane.
    for (int i = 0; i < 8; i++) wr(i, 8'd1);
    send(pix(8'd1, 8'd2, 8'd3, 8'd4));
    wait_out(n, sr);
    check("latency", n, 6);
    check("in_ready_mac_act", sr, 1'b0);
    check("all1_relu", out_pixel, 32'h000A_000A);
    check("all1_clamp", out_pixel_c, 32'h0006_0006);
    check("all1_sat8", out_pixel_s, 16'h0A0A);
    tick();
    check("consumed_idle", out_valid, 1'b0);

    // Lane 1 weights -1.
    for (int i = 4; i < 8; i++) wr(i, 8'hFF);
    send(pix(8'd1, 8'd2, 8'd3, 8'd4));
    wait_out(n, sr);
    check("neg_relu", out_pixel, 32'h0000_000A);
    check("neg_clamp", out_pixel_c, 32'h0000_0006);
    check("neg_noact", out_pixel_s, 16'hF60A);
    tick();

    // Saturation: 4*127*127 = 64516, 4*127*-128 = -65024.
    for (int i = 0; i < 8; i++) wr(i, 8'h7F);
    send(pix(8'd127, 8'd127, 8'd127, 8'd127));
    wait_out(n, sr);
    check("satp_sat8", out_pixel_s, 16'h7F7F);
    check("satp_relu16", out_pixel, 32'h7FFF_7FFF);
    check("satp_clamp", out_pixel_c, 32'h0006_0006);
    tick();
    for (int i = 0; i < 8; i++) wr(i, 8'h80);
    send(pix(8'd127, 8'd127, 8'd127, 8'd127));
    wait_out(n, sr);
    check("satn_sat8", out_pixel_s, 16'h8080);
    check("satn_relu16", out_pixel, 32'h0);
    tick();

    // Backpressure then back-to-back accept.
    for (int i = 0; i < 8; i++) wr(i, 8'd1);
    out_ready = 1'b0;
    send(pix(8'd1, 8'd2, 8'd3, 8'd4));
    wait_out(n, sr);
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_pixel", out_pixel, 32'h000A_000A);
      check("hold_in_ready", in_ready, 1'b0);
      tick();
    end
    in_valid  = 1'b1;
    in_pixel  = pix(8'd2, 8'd2, 8'd2, 8'd2);
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    wait_out(n, sr);
    check("b2b_latency", n, 6);
    check("b2b_pixel", out_pixel, 32'h0008_0008);
    tick();

    // Write during MAC is dropped.
    send(pix(8'd1, 8'd2, 8'd3, 8'd4));
    w_wr_en   = 1'b1;
    w_wr_addr = 4'd0;
    w_wr_data = 8'd5;
    tick();
    w_wr_en = 1'b0;
    check("drop_mac_pulse", drop_a, 1'b1);
    tick();
    check("drop_mac_clear", drop_a, 1'b0);
    wait_out(n, sr);
    check("drop_mac_result", out_pixel, 32'h000A_000A);
    tick();

    // Address 8 (bias slot of lane 0) is unmapped without the bias option.
    wr(8, 8'd0);
`ifdef CONV2D_PW_BIAS_EN
    check("addr8_drop", drop_a, 1'b0);
`else
    check("addr8_drop", drop_a, 1'b1);
`endif
    tick();

    // Write addr 0 together with accept: new weight 3 used by this pixel.
    w_wr_en   = 1'b1;
    w_wr_addr = 4'd0;
    w_wr_data = 8'd3;
    in_valid  = 1'b1;
    in_pixel  = pix(8'd1, 8'd2, 8'd3, 8'd4);
    tick();
    w_wr_en  = 1'b0;
    in_valid = 1'b0;
    check("wr_accept_nodrop", drop_a, 1'b0);
    wait_out(n, sr);
    check("wr_accept_result", out_pixel, 32'h000A_000C);
    tick();

    // Reset in the second MAC cycle.
    send(pix(8'd1, 8'd2, 8'd3, 8'd4));
    tick();
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_pixel", out_pixel, 32'h0);
    send(pix(8'd1, 8'd2, 8'd3, 8'd4));
    wait_out(n, sr);
    check("zero_weights", out_pixel, 32'h0);
    tick();
    for (int i = 0; i < 8; i++) wr(i, 8'd1);
`ifdef CONV2D_PW_BIAS_EN
    wr(8, 8'd5);
    wr(9, 8'd5);
`endif
    send(pix(8'd1, 8'd2, 8'd3, 8'd4));
    wait_out(n, sr);
`ifdef CONV2D_PW_BIAS_EN
    check("post_rst_result", out_pixel, 32'h000F_000F);
`else
    check("post_rst_result", out_pixel, 32'h000A_000A);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2d_pw_stream.md
Name: conv2d_pw_stream

Overview:
- Streaming point-wise (1x1) convolution engine. One pixel vector (all IN_CHANNEL values) comes in per handshake; one output vector (all OUT_CHANNEL values) goes out.
- Replaces the fully-unrolled combinational pw conv with a time-multiplexed one. OUT_CHANNEL MAC lanes run in parallel and iterate serially over input channels.
- Weights are held internally and loaded through a write port.
- Sits between feature-map line buffers and the next layer, e.g. after a depth-wise conv.

Parameters:
- BITWIDTH, 8, signed width of pixels and weights.
- IS_BITWIDTH_DOUBLE_SCALE, 1, output width OUT_W = BITWIDTH*(IS_BITWIDTH_DOUBLE_SCALE+1).
- IN_CHANNEL, 4, number of input channels (>=1).
- OUT_CHANNEL, 8, number of output channels / MAC lanes (>=1).
- USING_ACTIVATION, 1, 1 = apply activation, 0 = pass the saturated value through.
- ACTIVATION_IS_RELU, 1, 1 = ReLU, 0 = ReLU6-style clamp to [0, ACTIVATION_MAX_VAL].
- ACTIVATION_MAX_VAL, 6, integer upper clamp, used when ACTIVATION_IS_RELU=0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- w_wr_en  in  1  weight/bias write strobe.
- w_wr_addr  in  AW  word address, AW = clog2(IN_CHANNEL*OUT_CHANNEL+OUT_CHANNEL); weight addr = oc*IN_CHANNEL+ic.
- w_wr_data  in  BITWIDTH  signed weight/bias value.
- w_wr_drop  out  1  one-cycle pulse when a write is ignored.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  input pixel accepted when in_valid && in_ready.
- in_pixel  in  IN_CHANNEL*BITWIDTH  channel ic at bits [ic*BITWIDTH +: BITWIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_pixel  out  OUT_CHANNEL*OUT_W  channel oc at [oc*OUT_W +: OUT_W].
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_pixel=0, busy=0, w_wr_drop=0, all weights/biases=0, accumulators=0, channel counter=0. Reset in any state, including mid-MAC or holding output, aborts immediately; the held result is discarded.
- FSM has four states:
  - IDLE: in_ready=1. On accept, latch in_pixel into the input register, clear accumulators (or load bias), set ic=0, go to MAC.
  - MAC: each cycle every lane does acc += px[ic]*w[oc][ic] (signed 2*BITWIDTH product). ic increments; after ic==IN_CHANNEL-1, go to ACT. Takes exactly IN_CHANNEL cycles.
  - ACT: saturate acc to signed OUT_W range, apply activation, register into out_pixel, set out_valid=1, go to OUT.
  - OUT: hold out_pixel/out_valid stable until out_ready. On out_valid && out_ready: if in_valid, accept the new pixel that same cycle and go to MAC; otherwise go to IDLE. in_ready = (state==IDLE) || (state==OUT && out_ready).
- Latency: accept at cycle T gives out_valid at T+IN_CHANNEL+2. Peak throughput is one pixel per IN_CHANNEL+2 cycles.
- Accumulator width ACC_W = 2*BITWIDTH + clog2(IN_CHANNEL) + 1; it never overflows.
- Saturation: values above 2^(OUT_W-1)-1 clamp to that value; values below -2^(OUT_W-1) clamp to that value.
- Activation:
  - ReLU: negative results become 0.
  - Clamp mode: results become min(max(x,0), ACTIVATION_MAX_VAL).
  - Activation is applied after saturation.
- Weight writes:
  - Accepted only while state==IDLE and rst=0.
  - A write in any other state, or to an address that is not mapped, is ignored and pulses w_wr_drop the next cycle.
  - A write and an input accept in the same IDLE cycle: the write commits first, and the new value is used by that pixel.

Optional Feature:
- Macro CONV2D_PW_BIAS_EN.
- Defined:
  - Addresses IN_CHANNEL*OUT_CHANNEL+oc write bias[oc].
  - On accept, acc[oc] initialises to bias[oc], sign-extended to ACC_W.
- Undefined:
  - Accumulators initialise to 0.
  - Bias addresses are unmapped and are dropped with a w_wr_drop pulse.

Decomposition:
- Package conv_pkg:
  - clog2 function.
  - ACC_W/OUT_W derivation functions.
  - Signed saturate function.
  - FSM state encoding constants (IDLE, MAC, ACT, OUT).
- Sub-module pw_mac_lane: one output channel's accumulator, saturation and activation; instantiated OUT_CHANNEL times in a generate loop.
- The top level owns the FSM, input register, channel counter and weight register file.

Test Plan:
- All weights=1 (IN=4, OUT=2), pixel {1,2,3,4}, out_ready=1 -> out_pixel = {10,10}; out_valid rises exactly 6 cycles after accept; in_ready=0 during MAC/ACT.
- Lane 1 weights=-1, ReLU -> lane1=0, lane0=10. With ACTIVATION_IS_RELU=0, MAX=6 -> lane0=6.
- IS_BITWIDTH_DOUBLE_SCALE=0, weights=127, pixel all 127, USING_ACTIVATION=0 -> 64516 saturates to 127. With weights=-128 the output is -128.
- out_ready held low 5 cycles -> out_pixel/out_valid stable, in_ready=0. Raise out_ready with in_valid=1 -> back-to-back accept in that cycle, next result 6 cycles later.
- w_wr_en during MAC -> weight unchanged, w_wr_drop pulses. Write addr 0 in the same cycle as an IDLE accept -> new weight used in that result.
- Assert rst in the 2nd MAC cycle -> next cycle IDLE, out_valid=0, in_ready=1, weights read back 0. The following pixel computes correctly (bias variant: bias=5 -> {15,15}).
